// File: rtl/mul_seq_4b_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and the iteration-counter width helper.
package mul_seq_4b_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must hold the value WIDTH itself, hence one bit above log2.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/mul_seq_4b_add_4b.sv
// 4-bit ripple adder slice; the multiplier chains WIDTH/4 of these
// carry-out to carry-in to form its accumulator adder.
module add_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'd0, cin};

endmodule

// File: rtl/mul_seq_4b.sv
// Sequential unsigned shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH,
// one partial product per clock through a chain of add_4b slices.
module mul_seq_4b
    import mul_seq_4b_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int NB = WIDTH / 4;
    localparam int CW = cnt_width(WIDTH);

    // Handshake: start is a request sampled only in IDLE; an accepted start
    // raises busy on the same edge, busy stays high for exactly WIDTH cycles,
    // then done pulses for one cycle with product valid. Requests seen while
    // busy or done are dropped, never queued.

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   m_r, acc_r, q_r;
    logic               c_r;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   addend, sum;
    logic [NB:0]        carry;
    logic               top_carry;
    logic               last;

    assign addend    = q_r[0] ? m_r : '0;
    assign carry[0]  = 1'b0;
    assign last      = (cnt == CW'(1));
    // C extends the accumulator to WIDTH+1 bits; it is zero after every shift.
    assign top_carry = carry[NB] | c_r;

    for (genvar g = 0; g < NB; g++) begin : g_add
        add_4b u_add (
            .a    (acc_r[4*g +: 4]),
            .b    (addend[4*g +: 4]),
            .cin  (carry[g]),
            .sum  (sum[4*g +: 4]),
            .cout (carry[g+1])
        );
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (last)  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == ST_RUN);
            done  <= (state_nxt == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_r     <= '0;
            acc_r   <= '0;
            q_r     <= '0;
            c_r     <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        m_r     <= a;
                        q_r     <= b;
                        acc_r   <= '0;
                        c_r     <= 1'b0;
                        cnt     <= CW'(WIDTH);
                        product <= '0;
                    end
                end
                ST_RUN: begin
                    // {C,A,Q} <= {carry,sum,Q} >> 1
                    c_r   <= 1'b0;
                    acc_r <= {top_carry, sum[WIDTH-1:1]};
                    q_r   <= {sum[0], q_r[WIDTH-1:1]};
                    cnt   <= cnt - CW'(1);
                    if (last) product <= {top_carry, sum, q_r[WIDTH-1:1]};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_4b.sv
// Directed self-checking bench for mul_seq_4b (WIDTH=4): latency, products,
// ignored starts, asynchronous reset mid-run and back-to-back operation.
module tb_mul_seq_4b;

    localparam int WIDTH = 4;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [WIDTH-1:0]   a, b;
    logic               busy, done;
    logic [2*WIDTH-1:0] product;

    int checks = 0;
    int errors = 0;

    mul_seq_4b #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Runs one multiply; inj_cycle>0 pulses a competing start (7x7) in that busy cycle.
    task automatic do_mul(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                          input logic [2*WIDTH-1:0] expp, input int inj_cycle);
        int extra_done;
        @(negedge clk);
        a = ai; b = bi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = WIDTH'($urandom_range(0, 15));
        b = WIDTH'($urandom_range(0, 15));
        check("accept_product_clear", 32'(product), 32'd0);
        for (int i = 1; i <= WIDTH; i++) begin
            @(negedge clk);
            check($sformatf("busy_c%0d", i), 32'(busy), 32'd1);
            check($sformatf("nodone_c%0d", i), 32'(done), 32'd0);
            if (i == inj_cycle) begin
                start = 1'b1; a = 4'd7; b = 4'd7;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy_low", 32'(busy), 32'd0);
        check("product", 32'(product), 32'(expp));
        @(posedge clk); #1;
        check("done_single", 32'(done), 32'd0);
        check("product_hold", 32'(product), 32'(expp));
        extra_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        check("no_extra_done", 32'(extra_done), 32'd0);
        check("product_hold_idle", 32'(product), 32'(expp));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b1; start = 1'b0; a = '0; b = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // 1: basic latency and product
        do_mul(4'd3, 4'd5, 8'h0F, 0);
        // 2: carry-out into A[MSB]
        do_mul(4'hF, 4'hF, 8'hE1, 0);
        // 3: zero operands, full latency
        do_mul(4'd0, 4'd9, 8'h00, 0);
        do_mul(4'd9, 4'd0, 8'h00, 0);
        // 4: start while busy is dropped
        do_mul(4'd2, 4'd6, 8'h0C, 2);

        // 5: asynchronous reset mid-run, after iteration 2
        @(negedge clk);
        a = 4'd13; b = 4'd11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_product", 32'(product), 32'd0);
        repeat (2) @(negedge clk) check("rst_hold_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk) check("post_rst_nodone", 32'(done), 32'd0);
        do_mul(4'd13, 4'd11, 8'h8F, 0);

        // 6: start held high -> one result per WIDTH+2 cycles
        @(negedge clk);
        a = 4'd6; b = 4'd7; start = 1'b1;
        for (int r = 0; r < 3; r++) begin
            @(posedge clk); #1;
            check($sformatf("bb_accept_clear_r%0d", r), 32'(product), 32'd0);
            check($sformatf("bb_busy_r%0d", r), 32'(busy), 32'd1);
            repeat (WIDTH) @(posedge clk);
            #1;
            check($sformatf("bb_done_r%0d", r), 32'(done), 32'd1);
            check($sformatf("bb_product_r%0d", r), 32'(product), 32'h2A);
            @(posedge clk); #1;
            check($sformatf("bb_gap_done_r%0d", r), 32'(done), 32'd0);
            check($sformatf("bb_gap_busy_r%0d", r), 32'(busy), 32'd0);
            check($sformatf("bb_gap_hold_r%0d", r), 32'(product), 32'h2A);
        end
        start = 1'b0;
        repeat (8) @(posedge clk);

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
